// File: rtl/mips_trace_pkg.sv
// rtl/mips_trace_pkg.sv - shared state, trace kind and trace entry types for the MIPS run monitor
package mips_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic TR_REG = 1'b0;
  localparam logic TR_MEM = 1'b1;

  localparam int TR_ADDR_W  = 8;
  localparam int TR_DATA_W  = 16;
  localparam int TR_CYCLE_W = 16;

  // Field order matches the packed trace word carried through the FIFO
  typedef struct packed {
    logic                  kind;
    logic [TR_ADDR_W-1:0]  addr;
    logic [TR_DATA_W-1:0]  data;
    logic [TR_CYCLE_W-1:0] cycle;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - trace FIFO with two ordered push ports and one valid/ready pop port
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push_a,
  input  logic [W-1:0]  data_a,
  input  logic          push_b,
  input  logic [W-1:0]  data_b,
  input  logic          pop_ready,
  output logic          head_valid,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] free
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wr_b;
  logic [1:0]    w_n_push;
  logic          w_pop;

  assign head_valid = (r_count != '0);
  assign w_pop      = head_valid && pop_ready;
  assign w_n_push   = {1'b0, push_a} + {1'b0, push_b};
  // Port b lands behind port a when both push in the same cycle
  assign w_wr_b     = r_wr + PW'(push_a);

  always_ff @(posedge clock) begin
    if (push_a) r_mem[r_wr] <= data_a;
    if (push_b) r_mem[w_wr_b] <= data_b;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + PW'(w_n_push);
      r_rd    <= r_rd + PW'(w_pop);
      r_count <= r_count + CW'(w_n_push) - CW'(w_pop);
    end
  end

  assign head_data = head_valid ? r_mem[r_rd] : '0;
  assign free      = CW'(DEPTH) - r_count;

endmodule

// File: rtl/mips_trace_monitor.sv
// rtl/mips_trace_monitor.sv - run monitor for mips16_sc: cycle count, self-loop halt detect, write trace
module mips_trace_monitor
  import mips_trace_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_ADDR_W  = 8,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4,
  parameter int CYCLE_W     = 16,
  localparam int ADDR_W     = (REG_ADDR_W > MEM_ADDR_W) ? REG_ADDR_W : MEM_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     pc,
  input  logic                  reg_write_en,
  input  logic [REG_ADDR_W-1:0] reg_write_addr,
  input  logic [DATA_W-1:0]     reg_write_data,
  input  logic                  mem_write_en,
  input  logic [MEM_ADDR_W-1:0] mem_write_addr,
  input  logic [DATA_W-1:0]     mem_write_data,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic                  trace_kind,
  output logic [ADDR_W-1:0]     trace_addr,
  output logic [DATA_W-1:0]     trace_data,
  output logic [CYCLE_W-1:0]    trace_cycle,
  output logic                  running,
  output logic                  done,
  output logic [DATA_W-1:0]     halt_pc,
  output logic [CYCLE_W-1:0]    cycle_count,
  output logic                  overflow,
  output logic [CYCLE_W-1:0]    dropped_count
);

  localparam int ENTRY_W = 1 + ADDR_W + DATA_W + CYCLE_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int STB_W   = $clog2(HALT_CYCLES) + 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [DATA_W-1:0]  r_prev_pc;
  logic               r_pc_valid;
  logic [DATA_W-1:0]  r_halt_pc;
  logic [STB_W-1:0]   r_stable;
  logic [STB_W-1:0]   w_stable_next;
  logic [CYCLE_W-1:0] r_cycle;
  logic [CYCLE_W-1:0] r_stable_idx;
  logic [CYCLE_W-1:0] r_dropped;
  logic               r_overflow;
  logic               w_in_run;
  logic               w_enter_run;
  logic               w_pc_match;
  logic               w_halt;
  logic               w_push_reg;
  logic               w_push_mem;
  logic [1:0]         w_drop_n;
  logic [CYCLE_W:0]   w_drop_sum;
  logic [CNT_W-1:0]   w_free;
  logic [ENTRY_W-1:0] w_reg_entry;
  logic [ENTRY_W-1:0] w_mem_entry;
  logic [ENTRY_W-1:0] w_head;

  assign w_in_run      = (r_state == ST_RUN);
  assign w_enter_run   = start && !w_in_run;
  assign w_pc_match    = r_pc_valid && (pc == r_prev_pc);
  assign w_stable_next = w_pc_match ? r_stable + STB_W'(1) : '0;
  assign w_halt        = w_in_run && (w_stable_next == STB_W'(HALT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_halt) w_state_next = ST_DONE;
      ST_DONE: if (start)  w_state_next = ST_RUN;
      default:             w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    case (r_state)
      ST_RUN:  running = 1'b1;
      ST_DONE: done    = 1'b1;
      default: ;
    endcase
  end

  // r_stable_idx remembers where the current PC value first appeared, so the halt
  // cycle index stays correct even after the cycle counter saturates
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle      <= '0;
      r_stable     <= '0;
      r_stable_idx <= '0;
      r_prev_pc    <= '0;
      r_pc_valid   <= 1'b0;
      r_halt_pc    <= '0;
    end else if (w_enter_run) begin
      r_cycle      <= '0;
      r_stable     <= '0;
      r_stable_idx <= '0;
      r_pc_valid   <= 1'b0;
    end else if (w_in_run) begin
      r_prev_pc  <= pc;
      r_pc_valid <= 1'b1;
      r_stable   <= w_stable_next;
      if (!w_pc_match) r_stable_idx <= r_cycle;
      if (w_halt) begin
        r_cycle   <= r_stable_idx;
        r_halt_pc <= pc;
      end else if (r_cycle != '1) begin
        r_cycle <= r_cycle + CYCLE_W'(1);
      end
    end
  end

  // Free space is the start-of-cycle figure; a same-cycle pop never makes room
  always_comb begin
    w_push_reg = 1'b0;
    w_push_mem = 1'b0;
    w_drop_n   = 2'd0;
    if (w_in_run) begin
      if (reg_write_en) begin
        if (w_free != '0) w_push_reg = 1'b1;
        else              w_drop_n   = 2'd1;
      end
      if (mem_write_en) begin
        if (w_free > CNT_W'(w_push_reg)) w_push_mem = 1'b1;
        else                             w_drop_n   = w_drop_n + 2'd1;
      end
    end
  end

  assign w_drop_sum = {1'b0, r_dropped} + (CYCLE_W + 1)'(w_drop_n);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else if (w_enter_run) begin
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else if (w_drop_n != 2'd0) begin
      r_overflow <= 1'b1;
      r_dropped  <= w_drop_sum[CYCLE_W] ? '1 : w_drop_sum[CYCLE_W-1:0];
    end
  end

  assign w_reg_entry = {TR_REG, ADDR_W'(reg_write_addr), reg_write_data, r_cycle};
  assign w_mem_entry = {TR_MEM, ADDR_W'(mem_write_addr), mem_write_data, r_cycle};

  trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_a     (w_push_reg),
    .data_a     (w_reg_entry),
    .push_b     (w_push_mem),
    .data_b     (w_mem_entry),
    .pop_ready  (trace_ready),
    .head_valid (trace_valid),
    .head_data  (w_head),
    .free       (w_free)
  );

  assign {trace_kind, trace_addr, trace_data, trace_cycle} = w_head;
  assign halt_pc       = r_halt_pc;
  assign cycle_count   = r_cycle;
  assign overflow      = r_overflow;
  assign dropped_count = r_dropped;

endmodule

// File: tb/tb_mips_trace_monitor.sv
// tb/tb_mips_trace_monitor.sv - scoreboard bench for mips_trace_monitor
module tb_mips_trace_monitor;
  import mips_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int HALT  = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pc = '0;
  logic        reg_write_en = 1'b0;
  logic [2:0]  reg_write_addr = '0;
  logic [15:0] reg_write_data = '0;
  logic        mem_write_en = 1'b0;
  logic [7:0]  mem_write_addr = '0;
  logic [15:0] mem_write_data = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic        trace_kind;
  logic [7:0]  trace_addr;
  logic [15:0] trace_data;
  logic [15:0] trace_cycle;
  logic        running;
  logic        done;
  logic [15:0] halt_pc;
  logic [15:0] cycle_count;
  logic        overflow;
  logic [15:0] dropped_count;

  always #5 clock = ~clock;

  mips_trace_monitor #(
    .DATA_W(16), .REG_ADDR_W(3), .MEM_ADDR_W(8),
    .DEPTH(DEPTH), .HALT_CYCLES(HALT), .CYCLE_W(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pc(pc),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_kind(trace_kind),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_cycle(trace_cycle),
    .running(running), .done(done), .halt_pc(halt_pc), .cycle_count(cycle_count),
    .overflow(overflow), .dropped_count(dropped_count)
  );

  trace_entry_t sb[$];
  trace_entry_t mon_got;
  trace_entry_t mon_exp;
  int n_checks = 0;
  int n_err = 0;

  int          m_count = 0;
  bit          m_run = 0;
  bit          m_have_pc = 0;
  logic [15:0] m_prev_pc = '0;
  int          m_stable = 0;
  int          m_cycle = 0;
  int          m_first_idx = 0;
  int          m_dropped = 0;
  logic [15:0] cur_pc = '0;

  always @(negedge clock) begin
    if (reset_n && trace_valid && trace_ready) begin
      mon_got = {trace_kind, trace_addr, trace_data, trace_cycle};
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL trace_extra got=%h expected=none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL trace_entry got=%h expected=%h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic step(input logic [15:0] p, input logic rw, input logic [2:0] ra,
                      input logic [15:0] rd, input logic mw, input logic [7:0] ma,
                      input logic [15:0] md);
    int free;
    int npush;
    int ndrop;
    bit go;
    bit pop;
    trace_entry_t e;
    pc = p;
    reg_write_en = rw; reg_write_addr = ra; reg_write_data = rd;
    mem_write_en = mw; mem_write_addr = ma; mem_write_data = md;
    go = start && !m_run;
    pop = (m_count > 0) && trace_ready;
    npush = 0;
    ndrop = 0;
    if (m_run) begin
      free = DEPTH - m_count;
      if (rw) begin
        if (free >= 1) begin
          e = {TR_REG, 8'(ra), rd, 16'(m_cycle)};
          sb.push_back(e);
          npush++;
        end else ndrop++;
      end
      if (mw) begin
        if (free >= npush + 1) begin
          e = {TR_MEM, ma, md, 16'(m_cycle)};
          sb.push_back(e);
          npush++;
        end else ndrop++;
      end
      if (ndrop > 0) m_dropped = (m_dropped + ndrop > 65535) ? 65535 : m_dropped + ndrop;
      if (m_have_pc && p == m_prev_pc) m_stable++;
      else begin
        m_stable = 0;
        m_first_idx = m_cycle;
      end
      m_prev_pc = p;
      m_have_pc = 1;
      if (m_stable == HALT - 1) begin
        m_run = 0;
        m_cycle = m_first_idx;
      end else if (m_cycle < 65535) m_cycle++;
    end
    if (go) begin
      m_run = 1; m_cycle = 0; m_stable = 0; m_have_pc = 0; m_dropped = 0;
    end
    m_count = m_count + npush - (pop ? 1 : 0);
    @(posedge clock);
    #1;
    reg_write_en = 1'b0;
    mem_write_en = 1'b0;
  endtask

  task automatic idle();
    cur_pc++;
    step(cur_pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step(cur_pc, 0, 0, 0, 0, 0, 0);
    start = 1'b0;
  endtask

  task automatic halt_run();
    cur_pc++;
    repeat (HALT) step(cur_pc, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (done !== 1'b1 || cycle_count !== 16'(m_cycle)) begin
      n_err++;
      $display("FAIL halt_run done=%b cycle_count=%0d expected done=1 cycle_count=%0d", done, cycle_count, m_cycle);
    end
  endtask

  task automatic drain();
    trace_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() > 0; i++) idle();
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout left=%0d expected=0", sb.size());
    end
    n_checks++;
    if (trace_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty trace_valid=%b expected=0", trace_valid);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    n_checks++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running got=%b expected=0", running); end
    n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b expected=0", done); end
    n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
    n_checks++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b expected=0", trace_valid); end
    n_checks++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL reset_cycle got=%0d expected=0", cycle_count); end
    n_checks++; if (dropped_count !== 16'd0) begin n_err++; $display("FAIL reset_dropped got=%0d expected=0", dropped_count); end
    n_checks++; if (halt_pc !== 16'd0) begin n_err++; $display("FAIL reset_halt_pc got=%0d expected=0", halt_pc); end
    n_checks++;
    if ({trace_kind, trace_addr, trace_data, trace_cycle} !== 41'd0) begin
      n_err++;
      $display("FAIL reset_trace got=%h expected=0", {trace_kind, trace_addr, trace_data, trace_cycle});
    end
  endtask

  task automatic test_basic_run();
    logic [15:0] pcs [7] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};
    do_start();
    n_checks++; if (running !== 1'b1) begin n_err++; $display("FAIL basic_running got=%b expected=1", running); end
    for (int i = 0; i < 7; i++) begin
      step(pcs[i], 0, 0, 0, 0, 0, 0);
      if (i == 5) begin
        n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_early_done got=%b expected=0", done); end
      end
    end
    n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done got=%b expected=1", done); end
    n_checks++; if (running !== 1'b0) begin n_err++; $display("FAIL basic_running_end got=%b expected=0", running); end
    n_checks++; if (halt_pc !== 16'd3) begin n_err++; $display("FAIL basic_halt_pc got=%0d expected=3", halt_pc); end
    n_checks++; if (cycle_count !== 16'd3) begin n_err++; $display("FAIL basic_cycle_count got=%0d expected=3", cycle_count); end
    cur_pc = 16'd3;
    step(cur_pc, 1, 3'd2, 16'h00ee, 1, 8'h10, 16'h00ff);
    n_checks++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL done_write_ignored got=%b expected=0", trace_valid); end
    n_checks++; if (dropped_count !== 16'd0) begin n_err++; $display("FAIL done_no_drop got=%0d expected=0", dropped_count); end
  endtask

  task automatic test_trace_order();
    trace_ready = 1'b1;
    do_start();
    cur_pc++; step(cur_pc, 1, 3'd1, 16'd1, 0, 0, 0);
    idle();
    cur_pc++; step(cur_pc, 0, 0, 0, 1, 8'd80, 16'd5);
    start = 1'b1;
    idle();
    start = 1'b0;
    n_checks++;
    if (running !== 1'b1 || cycle_count !== 16'(m_cycle)) begin
      n_err++;
      $display("FAIL start_in_run running=%b cycle_count=%0d expected running=1 cycle_count=%0d", running, cycle_count, m_cycle);
    end
    drain();
    halt_run();
  endtask

  task automatic test_one_free_and_full_pop();
    trace_ready = 1'b0;
    do_start();
    for (int i = 0; i < DEPTH - 1; i++) begin
      cur_pc++;
      step(cur_pc, 1, 3'(i), 16'(100 + i), 0, 0, 0);
    end
    cur_pc++; step(cur_pc, 1, 3'd5, 16'haaaa, 1, 8'h10, 16'hbbbb);
    n_checks++; if (overflow !== 1'b1) begin n_err++; $display("FAIL one_free_overflow got=%b expected=1", overflow); end
    n_checks++; if (dropped_count !== 16'd1) begin n_err++; $display("FAIL one_free_dropped got=%0d expected=1", dropped_count); end
    trace_ready = 1'b1;
    cur_pc++; step(cur_pc, 1, 3'd6, 16'hcccc, 0, 0, 0);
    n_checks++; if (dropped_count !== 16'd2) begin n_err++; $display("FAIL full_pop_dropped got=%0d expected=2", dropped_count); end
    trace_ready = 1'b0;
    cur_pc++; step(cur_pc, 1, 3'd7, 16'hdddd, 1, 8'h20, 16'heeee);
    n_checks++; if (dropped_count !== 16'd3) begin n_err++; $display("FAIL after_pop_dropped got=%0d expected=3", dropped_count); end
    drain();
    halt_run();
  endtask

  task automatic test_backpressure();
    trace_ready = 1'b0;
    do_start();
    cur_pc++; step(cur_pc, 1, 3'd3, 16'h1234, 0, 0, 0);
    cur_pc++; step(cur_pc, 0, 0, 0, 1, 8'h44, 16'h5678);
    for (int k = 0; k < 5; k++) begin
      idle();
      n_checks++;
      if (trace_valid !== 1'b1 || {trace_kind, trace_addr, trace_data, trace_cycle} !== sb[0]) begin
        n_err++;
        $display("FAIL backpressure_hold valid=%b got=%h expected=%h", trace_valid,
                 {trace_kind, trace_addr, trace_data, trace_cycle}, sb[0]);
      end
    end
    n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL backpressure_overflow got=%b expected=0", overflow); end
    drain();
    halt_run();
  endtask

  task automatic test_back_to_back();
    trace_ready = 1'b1;
    do_start();
    for (int i = 0; i < 10; i++) begin
      cur_pc++;
      step(cur_pc, 1, 3'(i), 16'(16'h0300 + i), 0, 0, 0);
    end
    n_checks++; if (dropped_count !== 16'd0) begin n_err++; $display("FAIL b2b_dropped got=%0d expected=0", dropped_count); end
    drain();
    halt_run();
  endtask

  task automatic test_reset_mid_run();
    trace_ready = 1'b0;
    do_start();
    for (int i = 0; i < 3; i++) begin
      cur_pc++;
      step(cur_pc, 1, 3'(i), 16'(16'h0700 + i), 0, 0, 0);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (running !== 1'b0) begin n_err++; $display("FAIL midreset_running got=%b expected=0", running); end
    n_checks++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid got=%b expected=0", trace_valid); end
    n_checks++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL midreset_cycle got=%0d expected=0", cycle_count); end
    n_checks++; if (trace_data !== 16'd0) begin n_err++; $display("FAIL midreset_data got=%h expected=0", trace_data); end
    sb.delete();
    m_count = 0; m_run = 0; m_cycle = 0; m_dropped = 0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    do_start();
    trace_ready = 1'b1;
    cur_pc++; step(cur_pc, 1, 3'd2, 16'd7, 0, 0, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_trace_order();
    test_one_free_and_full_pop();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_trace_monitor.md
# mips_trace_monitor

Synthesisable run monitor for the 16-bit single-cycle MIPS core (`mips16_sc`). It watches the core's register-file and data-memory write ports, counts executed cycles, and detects program end (a jump-to-self loop). It also buffers every architectural write into a trace FIFO that a bench or debug host drains through a valid/ready port. It replaces hand-written `$monitor` checks with a parametrised, cycle-accurate record of a run.

## Interface
Parameters:
- DATA_W, 16, width of register/memory data and PC
- REG_ADDR_W, 3, register-file address width
- MEM_ADDR_W, 8, data-memory address width
- DEPTH, 16, trace FIFO entries (power of two, ≥2)
- HALT_CYCLES, 4, consecutive equal PC samples that declare halt (≥2)
- CYCLE_W, 16, cycle/event counter width

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin a run
- pc  in  DATA_W  core program counter
- reg_write_en / reg_write_addr / reg_write_data  in  1 / REG_ADDR_W / DATA_W  core register write port
- mem_write_en / mem_write_addr / mem_write_data  in  1 / MEM_ADDR_W / DATA_W  core memory write port
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  consumer accepts head
- trace_kind  out  1  0 = register write, 1 = memory write
- trace_addr  out  max(REG_ADDR_W,MEM_ADDR_W)  zero-extended address
- trace_data  out  DATA_W  written value
- trace_cycle  out  CYCLE_W  run cycle index of the write
- running  out  1  state == RUN
- done  out  1  state == DONE
- halt_pc  out  DATA_W  PC of the detected self-loop
- cycle_count  out  CYCLE_W  run cycles, frozen at done
- overflow  out  1  sticky: at least one event dropped
- dropped_count  out  CYCLE_W  events dropped, saturating

## Operation
- States: IDLE → RUN on start; RUN → DONE on halt; DONE → RUN on start. start in RUN is ignored.
- Entering RUN clears cycle_count, the stable-PC counter, overflow and dropped_count. FIFO contents are kept.
- RUN, cycle_count:
  - Increments every cycle; the first RUN cycle has index 0.
  - Saturates at all-ones.
- RUN, halt detection:
  - Each cycle, if pc equals the previous cycle's pc, the stable counter increments; otherwise it clears.
  - When the counter reaches HALT_CYCLES-1, the next edge enters DONE, latches halt_pc = pc, and sets cycle_count to the index of the first cycle that showed halt_pc.
- Trace capture:
  - Write events are captured only in RUN, including the cycle that triggers DONE. Events in IDLE or DONE are ignored.
  - Each enabled port pushes {kind, addr, data, current cycle index}.
  - If both ports fire in one cycle, the register entry is pushed ahead of the memory entry. Both need 2 free slots.
  - With 1 free slot, the register entry is kept and the memory entry is dropped. With 0 free slots, both are dropped.
- Drops set overflow and add 1 or 2 to dropped_count (saturating).
- Free space is judged on the occupancy at the start of the cycle: a same-cycle pop does not make room for a same-cycle push.
- FIFO pop occurs when trace_valid && trace_ready. trace_* outputs hold stable while trace_valid && !trace_ready.

## Timing
- Reset values: state IDLE; running, done, overflow, trace_valid = 0; cycle_count, dropped_count, halt_pc, trace_kind, trace_addr, trace_data, trace_cycle = 0; FIFO empty.
- Reset asserted mid-run: immediate return to the reset values above; all FIFO entries are lost.
- running rises the cycle after start is sampled.
- Push latency: an event sampled at edge N appears at the FIFO head (trace_valid = 1) after edge N, if the FIFO was empty.
- Pop: the head advances on the accepting edge. A full-throughput stream of 1 entry per cycle is supported.
- done rises on the edge after the HALT_CYCLES-th equal PC sample.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1, so full and empty are distinct.

## Structure
- Package mips_trace_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_DONE)
  - the trace kind constants TR_REG = 1'b0 and TR_MEM = 1'b1
  - the trace entry struct {kind, addr, data, cycle}
- Sub-module trace_fifo: parametrised DEPTH × entry width, two push ports (priority order), one valid/ready pop port, and a free-slot count output. The top level holds the FSM, the counters and the drop logic.

## Test plan
- Basic run: start, then pc runs 0,1,2,3,3,3,3 (HALT_CYCLES=4) → done after the 4th sample of 3, halt_pc = 3, cycle_count = 3, running = 0.
- Trace order: reg write (r1 = 1) at cycle 0, mem write (addr 80, data 5) at cycle 2, trace_ready = 1 → two entries, {0,1,1,0} then {1,80,5,2}; trace_valid then drops to 0.
- Simultaneous writes with 1 free slot: fill the FIFO to DEPTH-1 with trace_ready = 0, then fire reg and mem writes together → reg entry stored, overflow = 1, dropped_count = 1.
- Full plus pop same cycle: FIFO full, trace_ready = 1, one reg write in the same cycle → write dropped, count becomes DEPTH-1, dropped_count increments.
- Backpressure: trace_ready = 0 for 5 cycles with a valid head → trace_* outputs unchanged throughout; no loss while occupancy < DEPTH.
- Reset mid-run: assert reset_n = 0 while in RUN with 3 entries queued → all outputs at reset values immediately; a subsequent start begins at cycle index 0.
